// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// One step per cycle; sign handled by magnitude in, correction in FIX.
module muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic             sgn;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [WIDTH:0]   mul_sum;
    logic [AW-1:0]    mul_next;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   div_diff;
    logic [AW-1:0]    div_next;
    logic [AW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // Operand magnitudes; signed ops fall back to unsigned when disabled.
    assign sgn    = SIGNED_EN && !op[0];
    assign rs_neg = sgn & rs[WIDTH-1];
    assign rt_neg = sgn & rt[WIDTH-1];
    assign rs_mag = rs_neg ? -rs : rs;
    assign rt_mag = rt_neg ? -rt : rt;

    // Shift-add: add multiplicand to upper half when LSB set, shift right.
    assign mul_sum  = {1'b0, acc_q[AW-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, mag_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: acc = {remainder, quotient}, shift left, trial subtract.
    assign rem_sh   = acc_q[AW-1:WIDTH-1];
    assign div_diff = rem_sh - {1'b0, mag_q};
    assign div_next = div_diff[WIDTH]
                    ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_lo_q ? -acc_q : acc_q;
    assign quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_hi_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];

    // Next-state and datapath control for IDLE -> CALC -> FIX.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mag_d      = mag_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (start) begin
                    is_div_d = op[1];
                    cnt_d    = CW'(WIDTH - 1);
                    neg_lo_d = rs_neg ^ rt_neg;
                    neg_hi_d = rs_neg;
                    dz_d     = 1'b0;
                    state_d  = CALC;
                    if (op[1]) begin
                        mag_d = rt_mag;
                        acc_d = {{WIDTH{1'b0}}, rs_mag};
                        if (rt == '0) begin
                            dz_d    = 1'b1;
                            acc_d   = {{WIDTH{1'b0}}, rs};
                            state_d = FIX;
                        end
                    end else begin
                        mag_d = rs_mag;
                        acc_d = {{WIDTH{1'b0}}, rt_mag};
                    end
                end
            end
            CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FIX: begin
                state_d    = IDLE;
                done_d     = 1'b1;
                div_zero_d = dz_q;
                if (dz_q) begin
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = '1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[AW-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mag_q      <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mag_q      <= mag_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32, SIGNED_EN=1).
// Expected results come from a behavioural 64-bit model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs, rt;
    logic        mthi, mtlo;
    logic [31:0] wdata;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          t0;
    } exp_t;

    exp_t scb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    muldiv_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs(rs), .rt(rt), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, q, r;
        logic [63:0] p;
        logic [31:0] uq, ur;
        e.dz  = 1'b0;
        e.lat = 33;
        e.t0  = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            2'd0: p = 64'(sa * sb);
            2'd1: p = {32'h0, a} * {32'h0, b};
            default: begin
                if (b == 32'h0) begin
                    p     = {a, 32'hFFFF_FFFF};
                    e.dz  = 1'b1;
                    e.lat = 1;
                end else if (o == 2'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end else begin
                    uq = a / b;
                    ur = a % b;
                    p  = {ur, uq};
                end
            end
        endcase
        e.hi = p[63:32];
        e.lo = p[31:0];
        return e;
    endfunction

    // Compare each completion against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && done === 1'b1) begin
            if (scb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = scb.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("div_zero", div_zero, e.dz);
                chk("latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        e    = model(o, a, b);
        e.t0 = cyc + 1;
        scb.push_back(e);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && scb.size() != 0; i++) @(posedge clk);
        #1 chk("drain", scb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 2'd0;
        rs    = '0;
        rt    = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        @(negedge clk) reset = 1'b1;

        // mthi/mtlo while idle
        @(negedge clk);
        mthi  = 1'b1;
        wdata = 32'hA5A5_0001;
        @(posedge clk);
        #1 mthi = 1'b0;
        chk("mthi_idle", hi, 32'hA5A5_0001);
        @(negedge clk);
        mtlo  = 1'b1;
        wdata = 32'h0000_5A5A;
        @(posedge clk);
        #1 mtlo = 1'b0;
        chk("mtlo_idle", lo, 32'h0000_5A5A);

        // MULT -3 * 7 with busy profile
        issue(2'd0, 32'hFFFF_FFFD, 32'd7);
        chk("busy_e0", busy, 1);
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1 chk($sformatf("busy_e%0d", i), busy, 1);
            if (i == 16) chk("calc_hold_hi", hi, 32'hA5A5_0001);
        end
        @(posedge clk);
        #1;
        chk("busy_e33", busy, 0);
        chk("done_e33", done, 1);
        drain();

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);
        drain();
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();
        issue(2'd3, 32'd7, 32'd0);
        drain();

        // mthi and start during CALC must be ignored
        issue(2'd0, 32'h1234_5678, 32'hFFFF_0003);
        repeat (4) @(posedge clk);
        @(negedge clk);
        mthi  = 1'b1;
        wdata = 32'h0000_1234;
        start = 1'b1;
        op    = 2'd3;
        rs    = 32'd9;
        rt    = 32'd0;
        @(posedge clk);
        #1;
        mthi  = 1'b0;
        start = 1'b0;
        chk("busy_mthi_hi", hi, 32'd7);
        chk("busy_mthi_busy", busy, 1);

        // back-to-back start in the done cycle
        for (int i = 0; i < 60 && done !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        chk("done_seen", done, 1);
        issue(2'd3, 32'd100, 32'd7);
        drain();

        // reset at edge 10 of a DIVU
        issue(2'd3, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (9) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        scb.delete();
        @(negedge clk) reset = 1'b1;
        repeat (40) @(posedge clk);
        #1 chk("abort_idle", busy, 0);

        // random mix
        for (int k = 0; k < 8; k++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (k == 5) ? 32'h0 : $urandom;
            if (k == 2) rb = 32'h0000_0003;
            issue(ro, ra, rb);
            drain();
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; legal values are even and 4 or greater.
REQ-002 The module SHALL have parameter SIGNED_EN, default 1, which enables signed ops; when 0, signed ops execute as unsigned.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start.
REQ-007 rs  input  WIDTH  multiplicand or dividend; sampled with start.
REQ-008 rt  input  WIDTH  multiplier or divisor; sampled with start.
REQ-009 mthi  input  1  write wdata into HI; honoured only in IDLE.
REQ-010 mtlo  input  1  write wdata into LO; honoured only in IDLE.
REQ-011 wdata  input  WIDTH  data for mthi/mtlo.
REQ-012 hi  output  WIDTH  HI register: product upper half, or remainder.
REQ-013 lo  output  WIDTH  LO register: product lower half, or quotient.
REQ-014 busy  output  1  high while an operation is in flight.
REQ-015 done  output  1  one-cycle pulse when hi/lo take a new result.
REQ-016 div_zero  output  1  high with done when the divisor was 0; low otherwise.

Function
REQ-017 The FSM SHALL have three states: IDLE, CALC and FIX; busy=1 exactly in CALC and FIX.
REQ-018 On the start edge (edge 0) in IDLE, the unit SHALL latch op, the magnitudes of rs and rt (magnitude only for signed ops), and the result sign flags, then enter CALC with the iteration counter at WIDTH-1.
REQ-019 CALC SHALL run one radix-2 step per cycle for exactly WIDTH cycles: shift-add for multiply, restoring shift-subtract for divide; the counter decrements, and at 0 the next state is FIX.
REQ-020 FIX SHALL, in one cycle, apply sign correction, write hi/lo, set done=1 and return to IDLE; done is therefore high after edge WIDTH+1 and low on every other cycle.
REQ-021 Multiply SHALL produce the full 2*WIDTH product, with hi = upper half and lo = lower half; the product is negated when exactly one signed operand is negative.
REQ-022 Divide SHALL truncate toward zero: the quotient is negative when the operand signs differ, and the remainder takes the sign of the dividend.
REQ-023 For signed divide of the most-negative value by -1, the unit SHALL return lo = most-negative value, hi = 0, with no flag.
REQ-024 For a divide with rt=0, the unit SHALL skip CALC: edge 0 moves to FIX; after edge 1, hi = rs, lo = all ones, done=1, div_zero=1.
REQ-025 While busy, start, mthi and mtlo SHALL be ignored, with no queueing.
REQ-026 In IDLE, start together with mthi/mtlo SHALL apply the write at edge 0 and also accept the operation; the later result overwrites hi/lo.
REQ-027 hi/lo SHALL hold their value between operations, and SHALL NOT change during CALC.
REQ-028 A new start SHALL be accepted in the cycle where done is high, since the state is already IDLE.
REQ-029 The iteration counter SHALL be $clog2(WIDTH) bits; internal accumulators SHALL be 2*WIDTH+1 bits maximum.

Reset
REQ-030 When reset=0 at a clock edge, the unit SHALL go to IDLE with hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0, regardless of state.
REQ-031 A reset during CALC or FIX SHALL abort the operation, with no done pulse and no partial result visible.
REQ-032 While reset=0, start, mthi and mtlo SHALL be ignored.

Verification (WIDTH=32, SIGNED_EN=1)
REQ-033 Signed multiply: MULT rs=0xFFFFFFFD, rt=7 -> done after edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for edges 1..32.
REQ-034 Unsigned multiply: MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, div_zero=0.
REQ-035 Signed divide: DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; also DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 Divide by zero: DIVU rs=7, rt=0 -> after edge 1, done=1, div_zero=1, hi=7, lo=0xFFFFFFFF.
REQ-037 Ignored writes and back-to-back start: mthi with wdata=0x1234 at cycle 5 of a MULT -> ignored, result intact; start in the done cycle -> second op accepted, done 33 edges later.
REQ-038 Reset mid-operation: reset=0 at edge 10 of a DIVU -> next cycle hi=lo=0, busy=0; done never pulses for the aborted op.
